// File: rtl/rtc_access_sequencer_if.sv
// rtl/rtc_access_sequencer_if.sv - access request/done bus between sequencer and RTC bus driver
//
// master (sequencer): drives out_req, out_addr, out_wr, out_data, out_seq_data, out_busy; samples in_done
// slave  (driver)   : samples the request signals; drives in_done
`timescale 1ns/1ps

interface rtc_access_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              out_req;
  logic [ADDR_W-1:0] out_addr;
  logic              out_wr;
  logic [DATA_W-1:0] out_data;
  logic              out_seq_data;
  logic              out_busy;
  logic              in_done;

  modport master (
    output out_req, out_addr, out_wr, out_data, out_seq_data, out_busy,
    input  in_done
  );

  modport slave (
    input  out_req, out_addr, out_wr, out_data, out_seq_data, out_busy,
    output in_done
  );
endinterface

// File: rtl/rtc_access_sequencer.sv
// rtl/rtc_access_sequencer.sv - sequences every RTC register access (init, readout, config, write-back)
//
// Ports:
//   clk          system clock
//   reset_count  asynchronous active-high reset
//   in_sw        config switches {sw2,sw1,sw0}: 001 hour, 010 date, 100 timer
//   bus          rtc_access_sequencer_if.master: out_req pulse, out_addr/out_wr/out_data/out_seq_data
//                held per access, out_busy while outstanding, in_done from the driver
//   out_mode     current state encoding (IDLE=0 .. WR_TIMER=7)
//   out_conf     registered copy of in_sw
//   out_err      sticky watchdog error
// Optional feature: RTC_SEQ_TIMEOUT_EN enables the bus watchdog (TIMEOUT_W/TIMEOUT_CYC).
`timescale 1ns/1ps

module rtc_access_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                         clk,
  input  logic                         reset_count,
  input  logic [2:0]                   in_sw,
  rtc_access_sequencer_if.master       bus,
  output logic [2:0]                   out_mode,
  output logic [2:0]                   out_conf,
  output logic                         out_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    READ_CTE  = 3'd2,
    CFG_HOUR  = 3'd3,
    CFG_DATE  = 3'd4,
    CFG_TIMER = 3'd5,
    WR_TIME   = 3'd6,
    WR_TIMER  = 3'd7
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       wr;
    logic       seq;
    logic       last;
  } step_t;

  state_t     state;
  logic [3:0] step;
  logic       issue;     // a step has been entered; its request goes out on the next edge
  logic       done_acc;
  step_t      cur;

  // Fixed per-state access tables.
  function automatic step_t step_entry(input state_t s, input logic [3:0] i);
    step_t e;
    e = '0;
    case (s)
      INIT: begin
        e.wr   = 1'b1;
        e.seq  = 1'b1;
        e.last = (i == 4'd11);
        case (i)
          4'd0:    {e.addr, e.data} = 16'h0210;
          4'd1:    {e.addr, e.data} = 16'h0200;
          4'd2:    {e.addr, e.data} = 16'h10D2;
          4'd3:    {e.addr, e.data} = 16'h0000;
          4'd4:    {e.addr, e.data} = 16'h2100;
          4'd5:    {e.addr, e.data} = 16'h2200;
          4'd6:    {e.addr, e.data} = 16'h2300;
          4'd7:    {e.addr, e.data} = 16'h2401;
          4'd8:    {e.addr, e.data} = 16'h2501;
          4'd9:    {e.addr, e.data} = 16'h2600;
          4'd10:   {e.addr, e.data} = 16'h2701;
          default: {e.addr, e.data} = 16'hF100;
        endcase
      end
      READ_CTE: begin
        e.last = (i == 4'd10);
        if (i == 4'd0)      e.addr = 8'hF0;
        else if (i <= 4'd7) e.addr = 8'h20 + {4'd0, i};
        else                e.addr = 8'h39 + {4'd0, i};
      end
      CFG_HOUR: begin
        e.last = (i == 4'd3);
        e.addr = (i == 4'd0) ? 8'hF2 : 8'h40 + {4'd0, i};
      end
      CFG_DATE: begin
        e.last = (i == 4'd7);
        if (i == 4'd0)      e.addr = 8'hF1;
        else if (i <= 4'd3) e.addr = 8'h20 + {4'd0, i};
        else if (i == 4'd4) e.addr = 8'hF2;
        else                e.addr = 8'h3C + {4'd0, i};
      end
      CFG_TIMER: begin
        e.last = (i == 4'd7);
        e.addr = (i == 4'd0) ? 8'hF1 : 8'h20 + {4'd0, i};
      end
      WR_TIME: begin
        e.wr   = 1'b1;
        e.last = (i == 4'd7);
        e.addr = (i == 4'd7) ? 8'hF1 : 8'h21 + {4'd0, i};
      end
      WR_TIMER: begin
        e.wr   = 1'b1;
        e.last = (i == 4'd4);
        if (i <= 4'd2)      e.addr = 8'h41 + {4'd0, i};
        else if (i == 4'd3) e.addr = 8'hF2;
        else begin
          e.addr = 8'h00;
          e.data = 8'h08;
          e.seq  = 1'b1;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Where a state goes once its final access completes; conf is only consulted here.
  function automatic state_t pass_end(input state_t s, input logic [2:0] conf);
    state_t n;
    case (s)
      INIT:      n = READ_CTE;
      READ_CTE: begin
        case (conf)
          3'b001:  n = CFG_HOUR;
          3'b010:  n = CFG_DATE;
          3'b100:  n = CFG_TIMER;
          default: n = READ_CTE;
        endcase
      end
      CFG_HOUR:  n = (conf == 3'b000) ? WR_TIME  : CFG_HOUR;
      CFG_DATE:  n = (conf == 3'b000) ? WR_TIME  : CFG_DATE;
      CFG_TIMER: n = (conf == 3'b000) ? WR_TIMER : CFG_TIMER;
      WR_TIME:   n = READ_CTE;
      WR_TIMER:  n = READ_CTE;
      default:   n = INIT;
    endcase
    return n;
  endfunction

  assign cur      = step_entry(state, step);
  // Done in the request cycle itself, or with nothing outstanding, is a stray pulse.
  assign done_acc = bus.in_done & bus.out_busy & ~bus.out_req;
  assign out_mode = state;

`ifdef RTC_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_fire;
  assign wd_fire = bus.out_busy & ~done_acc & (wd_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_W, TIMEOUT_CYC};
  assign out_err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state            <= IDLE;
      step             <= 4'd0;
      issue            <= 1'b0;
      out_conf         <= 3'd0;
      bus.out_req      <= 1'b0;
      bus.out_addr     <= '0;
      bus.out_wr       <= 1'b0;
      bus.out_data     <= '0;
      bus.out_seq_data <= 1'b0;
      bus.out_busy     <= 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
      wd_cnt           <= '0;
      out_err          <= 1'b0;
`endif
    end else begin
      out_conf    <= in_sw;
      bus.out_req <= 1'b0;

      if (issue) begin
        issue            <= 1'b0;
        bus.out_req      <= 1'b1;
        bus.out_busy     <= 1'b1;
        bus.out_addr     <= ADDR_W'(cur.addr);
        bus.out_data     <= DATA_W'(cur.data);
        bus.out_wr       <= cur.wr;
        bus.out_seq_data <= cur.seq;
      end

      if (state == IDLE) begin
        state <= INIT;
        step  <= 4'd0;
        issue <= 1'b1;
      end else if (done_acc) begin
        bus.out_busy <= 1'b0;
        issue        <= 1'b1;
        if (cur.last) begin
          step  <= 4'd0;
          state <= pass_end(state, out_conf);
        end else begin
          step <= step + 4'd1;
        end
      end

`ifdef RTC_SEQ_TIMEOUT_EN
      // Abandon the stuck access and resume from the top of continuous readout.
      if (wd_fire) begin
        wd_cnt       <= '0;
        out_err      <= 1'b1;
        bus.out_busy <= 1'b0;
        state        <= READ_CTE;
        step         <= 4'd0;
        issue        <= 1'b1;
      end else if (done_acc) begin
        wd_cnt <= '0;
      end else if (bus.out_busy) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// tb/tb_rtc_access_sequencer.sv - scoreboard bench for rtc_access_sequencer
`timescale 1ns/1ps

module tb_rtc_access_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic       clk = 1'b0;
  logic       reset_count = 1'b1;
  logic [2:0] in_sw = 3'd0;
  logic       auto_done = 1'b0;
  logic       auto_pulse = 1'b0;
  logic       man_pulse = 1'b0;
  logic [2:0] out_mode;
  logic [2:0] out_conf;
  logic       out_err;

  rtc_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  assign bus.in_done = auto_pulse | man_pulse;

  rtc_access_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(16), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .reset_count(reset_count), .in_sw(in_sw), .bus(bus),
    .out_mode(out_mode), .out_conf(out_conf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // access record: {mode, wr, seq, addr, data}
  typedef logic [20:0] acc_t;
  acc_t exp_q[$];
  acc_t obs_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [7:0] init_a [12] = '{8'h02, 8'h02, 8'h10, 8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hF1};
  logic [7:0] init_d [12] = '{8'h10, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00};
  logic [7:0] rc_a   [11] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
  logic [7:0] hour_a [4]  = '{8'hF2, 8'h41, 8'h42, 8'h43};
  logic [7:0] tmr_a  [8]  = '{8'hF1, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
  logic [7:0] wt_a   [8]  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hF1};
  logic [7:0] wtr_a  [4]  = '{8'h41, 8'h42, 8'h43, 8'hF2};

  function automatic acc_t mk(logic [2:0] m, logic w, logic s, logic [7:0] a, logic [7:0] d);
    return {m, w, s, a, d};
  endfunction

  // Monitor: record each request; seq/data only carry meaning on sequencer-supplied writes.
  always @(posedge clk) begin
    #1;
    if (bus.out_req)
      obs_q.push_back(mk(out_mode, bus.out_wr, bus.out_wr & bus.out_seq_data, bus.out_addr,
                         (bus.out_wr & bus.out_seq_data) ? bus.out_data : 8'h00));
  end

  // Driver model: answer each request with a done pulse two cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_done && bus.out_req) begin
        @(negedge clk);
        @(negedge clk);
        auto_pulse = 1'b1;
        @(negedge clk);
        auto_pulse = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < n * 12 + 60; c++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (obs_q.size() >= n) ok = 1'b1;
  endtask

  task automatic sync_f0(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.out_req && out_mode == 3'd2 && bus.out_addr == 8'hF0) begin
        ok = 1'b1;
        break;
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_count = 1'b1;
    in_sw       = 3'd0;
    auto_done   = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.out_req, bus.out_busy, bus.out_wr, bus.out_seq_data, bus.out_addr, bus.out_data,
         out_mode, out_conf, out_err} !== 29'd0) begin
      fails++;
      $display("FAIL reset_values: got req=%b busy=%b wr=%b seq=%b addr=%h data=%h mode=%0d conf=%b err=%b, need all 0",
               bus.out_req, bus.out_busy, bus.out_wr, bus.out_seq_data, bus.out_addr, bus.out_data,
               out_mode, out_conf, out_err);
    end
    obs_q.delete();
    exp_q.delete();
    reset_count = 1'b0;
    @(negedge clk);
    tests++;
    if (out_mode !== 3'd1 || bus.out_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_edge1: got mode=%0d req=%b, need mode=1 req=0", out_mode, bus.out_req);
    end
    @(negedge clk);
    tests++;
    if (bus.out_req !== 1'b1 || bus.out_addr !== 8'h02 || bus.out_data !== 8'h10) begin
      fails++;
      $display("FAIL reset_first_req: got req=%b addr=%h data=%h, need req=1 addr=02 data=10",
               bus.out_req, bus.out_addr, bus.out_data);
    end
  endtask

  task automatic test_init();
    bit ok;
    acc_t e, o;
    for (int i = 0; i < 12; i++) exp_q.push_back(mk(3'd1, 1'b1, 1'b1, init_a[i], init_d[i]));
    for (int i = 0; i < 11; i++) exp_q.push_back(mk(3'd2, 1'b0, 1'b0, rc_a[i], 8'h00));
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL init_wait: got %0d accesses, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL init_access: got %h, need %h", o, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_cfg_hour();
    bit ok;
    acc_t e, o;
    sync_f0(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hour_sync: got no READ_CTE F0 request, need one"); end
    in_sw = 3'b001;
    for (int i = 1; i < 11; i++) exp_q.push_back(mk(3'd2, 1'b0, 1'b0, rc_a[i], 8'h00));
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'd3, 1'b0, 1'b0, hour_a[i], 8'h00));
    wait_obs(exp_q.size(), ok);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL hour_access: got %h, need %h", o, e); end
    end
    exp_q.delete();
    wait_obs(1, ok);
    in_sw = 3'b000;  // mid third pass
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'd3, 1'b0, 1'b0, hour_a[i], 8'h00));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(3'd6, 1'b1, 1'b0, wt_a[i], 8'h00));
    exp_q.push_back(mk(3'd2, 1'b0, 1'b0, 8'hF0, 8'h00));
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hour_wait: got %0d accesses, need %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL wr_time_access: got %h, need %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_cfg_timer();
    bit ok;
    acc_t e, o;
    sync_f0(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL timer_sync: got no READ_CTE F0 request, need one"); end
    in_sw = 3'b100;
    for (int i = 1; i < 11; i++) exp_q.push_back(mk(3'd2, 1'b0, 1'b0, rc_a[i], 8'h00));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(3'd5, 1'b0, 1'b0, tmr_a[i], 8'h00));
    wait_obs(exp_q.size(), ok);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL timer_access: got %h, need %h", o, e); end
    end
    exp_q.delete();
    wait_obs(1, ok);
    in_sw = 3'b000;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(3'd5, 1'b0, 1'b0, tmr_a[i], 8'h00));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'd7, 1'b1, 1'b0, wtr_a[i], 8'h00));
    exp_q.push_back(mk(3'd7, 1'b1, 1'b1, 8'h00, 8'h08));
    exp_q.push_back(mk(3'd2, 1'b0, 1'b0, 8'hF0, 8'h00));
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL timer_wait: got %0d accesses, need %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL wr_timer_access: got %h, need %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_stray_done();
    bit         found;
    bit         stalled_ok;
    logic [7:0] a0;
    logic [7:0] a_next;
    auto_done = 1'b0;
    found     = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.out_req) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL stray_sync: got no request, need one"); end
    a0     = bus.out_addr;
    a_next = 8'hXX;
    for (int i = 0; i < 11; i++) if (rc_a[i] == a0) a_next = rc_a[(i + 1) % 11];
    man_pulse = 1'b1;  // done in the request cycle
    @(negedge clk);
    man_pulse = 1'b0;
    tests++;
    if (bus.out_busy !== 1'b1 || bus.out_addr !== a0) begin
      fails++;
      $display("FAIL stray_req_cycle: got busy=%b addr=%h, need busy=1 addr=%h", bus.out_busy, bus.out_addr, a0);
    end
    stalled_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_req !== 1'b0 || bus.out_busy !== 1'b1 || bus.out_addr !== a0) stalled_ok = 1'b0;
    end
    tests++;
    if (!stalled_ok) begin
      fails++;
      $display("FAIL stray_stall: got req=%b busy=%b addr=%h, need req=0 busy=1 addr=%h",
               bus.out_req, bus.out_busy, bus.out_addr, a0);
    end
    man_pulse = 1'b1;
    @(negedge clk);
    man_pulse = 1'b0;
    tests++;
    if (bus.out_busy !== 1'b0) begin
      fails++;
      $display("FAIL stray_accept: got busy=%b, need 0", bus.out_busy);
    end
    man_pulse = 1'b1;  // done in the gap cycle, nothing outstanding
    @(negedge clk);
    man_pulse = 1'b0;
    tests++;
    if (bus.out_req !== 1'b1 || bus.out_addr !== a_next || out_mode !== 3'd2) begin
      fails++;
      $display("FAIL stray_next: got req=%b addr=%h mode=%0d, need req=1 addr=%h mode=2",
               bus.out_req, bus.out_addr, out_mode, a_next);
    end
    @(negedge clk);
    man_pulse = 1'b1;
    @(negedge clk);
    man_pulse = 1'b0;
    auto_done = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit   ok;
    bit   found;
    acc_t e, o;
    in_sw = 3'b001;
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (out_mode == 3'd3) begin found = 1'b1; break; end
    end
    in_sw = 3'b000;
    for (int c = 0; c < 1000 && found; c++) begin
      @(negedge clk);
      if (out_mode == 3'd6 && bus.out_req) begin found = 1'b1; break; end
      found = (c < 999);
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rst_mid_sync: got mode=%0d, need WR_TIME request", out_mode); end
    @(negedge clk);
    reset_count = 1'b1;
    #1;
    tests++;
    if (bus.out_busy !== 1'b0 || out_mode !== 3'd0 || bus.out_req !== 1'b0 || bus.out_addr !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_outputs: got busy=%b mode=%0d req=%b addr=%h, need 0/0/0/00",
               bus.out_busy, out_mode, bus.out_req, bus.out_addr);
    end
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    reset_count = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3'd1, 1'b1, 1'b1, init_a[i], init_d[i]));
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_mid_wait: got %0d accesses, need %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL rst_mid_init: got %h, need %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_watchdog();
    bit found;
    int n;
    tests++;
    if (out_err !== 1'b0) begin fails++; $display("FAIL wd_err_clear: got err=%b, need 0", out_err); end
    auto_done = 1'b0;
    found     = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.out_req) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL wd_sync: got no request, need one"); end
`ifdef RTC_SEQ_TIMEOUT_EN
    n = bus.out_busy ? 1 : 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_err) break;
      if (bus.out_busy) n++;
    end
    tests++;
    if (out_err !== 1'b1 || bus.out_busy !== 1'b0 || n != 20) begin
      fails++;
      $display("FAIL wd_fire: got err=%b busy=%b busy_cycles=%0d, need err=1 busy=0 busy_cycles=20",
               out_err, bus.out_busy, n);
    end
    @(negedge clk);
    tests++;
    if (bus.out_req !== 1'b1 || bus.out_addr !== 8'hF0 || out_mode !== 3'd2 || out_err !== 1'b1) begin
      fails++;
      $display("FAIL wd_restart: got req=%b addr=%h mode=%0d err=%b, need req=1 addr=F0 mode=2 err=1",
               bus.out_req, bus.out_addr, out_mode, out_err);
    end
`else
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.out_busy !== 1'b1 || bus.out_req !== 1'b0 || out_err !== 1'b0) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL wd_none: got %0d cycles not busy-waiting, need 0", n);
    end
`endif
    reset_count = 1'b1;
    @(negedge clk);
    reset_count = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_cfg_hour();
    test_cfg_timer();
    test_stray_done();
    test_reset_mid();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
